// File: rtl/conv3x3_unit.sv
// rtl/conv3x3_unit.sv - 3x3 sliding-window convolution lane with saturated registered output
// Kernel and window are column shift registers; column 2 is the newest column.
module conv3x3_unit #(
    parameter int BIT_LEN   = 8,
    parameter int M_LEN     = 3,
    parameter int CONV_LEN  = 20,
    parameter int CONV_LPOS = 13
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic [BIT_LEN-1:0]   i_dato0,
    input  logic [BIT_LEN-1:0]   i_dato1,
    input  logic [BIT_LEN-1:0]   i_dato2,
    input  logic                 i_selecK_I,
    input  logic                 i_valid,
    output logic [CONV_LPOS-1:0] o_data
);

    localparam int PROD_LEN = 2 * BIT_LEN + 1;
    localparam logic signed [CONV_LEN-1:0] SAT_MAX = CONV_LEN'((1 << (CONV_LPOS - 1)) - 1);
    localparam logic signed [CONV_LEN-1:0] SAT_MIN = -CONV_LEN'(1 << (CONV_LPOS - 1));

    logic signed [BIT_LEN-1:0]  kern [M_LEN][M_LEN];
    logic        [BIT_LEN-1:0]  win  [M_LEN][M_LEN];
    logic        [BIT_LEN-1:0]  new_col [M_LEN];
    logic signed [PROD_LEN-1:0] prod [M_LEN][M_LEN];
    logic signed [CONV_LEN-1:0] sum;
    logic        [CONV_LPOS-1:0] sat_val;

    assign new_col[0] = i_dato0;
    assign new_col[1] = i_dato1;
    assign new_col[2] = i_dato2;

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            for (int c = 0; c < M_LEN; c++) begin
                for (int r = 0; r < M_LEN; r++) begin
                    kern[c][r] <= '0;
                    win[c][r]  <= '0;
                end
            end
        end else if (i_valid) begin
            for (int r = 0; r < M_LEN; r++) begin
                if (i_selecK_I) begin
                    for (int c = 0; c < M_LEN - 1; c++) kern[c][r] <= kern[c+1][r];
                    kern[M_LEN-1][r] <= new_col[r];
                end else begin
                    for (int c = 0; c < M_LEN - 1; c++) win[c][r] <= win[c+1][r];
                    win[M_LEN-1][r] <= new_col[r];
                end
            end
        end
    end

    // Pixels are unsigned, so a zero MSB is prepended before the signed multiply.
    always_comb begin
        sum = '0;
        for (int c = 0; c < M_LEN; c++) begin
            for (int r = 0; r < M_LEN; r++) begin
                prod[c][r] = $signed({1'b0, win[c][r]}) * kern[c][r];
                sum = sum + {{(CONV_LEN - PROD_LEN){prod[c][r][PROD_LEN-1]}}, prod[c][r]};
            end
        end
    end

    always_comb begin
        sat_val = sum[CONV_LPOS-1:0];
        if (sum > SAT_MAX)
            sat_val = SAT_MAX[CONV_LPOS-1:0];
        else if (sum < SAT_MIN)
            sat_val = SAT_MIN[CONV_LPOS-1:0];
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst)
            o_data <= '0;
        else
            o_data <= sat_val;
    end

endmodule

// File: tb/tb_conv3x3_unit.sv
// tb/tb_conv3x3_unit.sv - directed and randomized checks of conv3x3_unit against a reference model
module tb_conv3x3_unit;

    logic        CLK100MHZ = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_dato0 = '0, i_dato1 = '0, i_dato2 = '0;
    logic        i_selecK_I = 1'b0;
    logic        i_valid = 1'b0;
    logic [12:0] o_data;

    int n_checks = 0;
    int n_err    = 0;
    int km [3][3];
    int wm [3][3];

    conv3x3_unit dut (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .i_dato0   (i_dato0),
        .i_dato1   (i_dato1),
        .i_dato2   (i_dato2),
        .i_selecK_I(i_selecK_I),
        .i_valid   (i_valid),
        .o_data    (o_data)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic int model_out();
        int s = 0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                s += km[c][r] * wm[c][r];
        if (s > 4095) return 4095;
        if (s < -4096) return -4096;
        return s;
    endfunction

    // One clock: drive inputs, advance the model, then compare o_data just after the edge.
    task automatic drive(input bit r, input bit v, input bit s, input int d0, input int d1, input int d2);
        int exp_v;
        logic [7:0] col [3];
        col[0] = d0[7:0]; col[1] = d1[7:0]; col[2] = d2[7:0];
        rst = r; i_valid = v; i_selecK_I = s;
        i_dato0 = col[0]; i_dato1 = col[1]; i_dato2 = col[2];
        exp_v = r ? 0 : model_out();
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                for (int j = 0; j < 3; j++) begin km[i][j] = 0; wm[i][j] = 0; end
            end else if (v && s) begin
                km[0][i] = km[1][i]; km[1][i] = km[2][i]; km[2][i] = int'($signed(col[i]));
            end else if (v) begin
                wm[0][i] = wm[1][i]; wm[1][i] = wm[2][i]; wm[2][i] = int'(col[i]);
            end
        end
        @(posedge CLK100MHZ);
        #1;
        check("model", o_data, exp_v[12:0]);
    endtask

    task automatic kcol(input int a, input int b, input int c);
        drive(0, 1, 1, a, b, c);
    endtask

    task automatic icol(input int a, input int b, input int c);
        drive(0, 1, 0, a, b, c);
    endtask

    task automatic idle();
        drive(0, 0, $urandom_range(0, 1), $urandom, $urandom, $urandom);
    endtask

    task automatic do_reset();
        drive(1, 1, $urandom_range(0, 1), $urandom, $urandom, $urandom);
        check("reset", o_data, 13'd0);
    endtask

    task automatic box_filter(input string tag);
        for (int i = 0; i < 3; i++) kcol(1, 1, 1);
        icol(10, 20, 30);
        icol(10, 20, 30); check({tag, "_60"}, o_data, 13'd60);
        icol(10, 20, 30); check({tag, "_120"}, o_data, 13'd120);
        idle();           check({tag, "_180"}, o_data, 13'd180);
    endtask

    initial begin
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) begin km[c][r] = 0; wm[c][r] = 0; end

        do_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); check("reset_hold", o_data, 13'd0);
        end

        box_filter("box");

        do_reset();
        kcol(0, 0, 0); kcol(0, 2, 0); kcol(0, 0, 0);
        icol(0, 5, 0);
        icol(0, 7, 0);  check("slide_0", o_data, 13'd0);
        icol(0, 9, 0);  check("slide_10", o_data, 13'd10);
        icol(0, 11, 0); check("slide_14", o_data, 13'd14);
        idle();         check("slide_18", o_data, 13'd18);
        for (int i = 0; i < 3; i++) kcol(1, 1, 1);
        idle();         check("reload_27", o_data, 13'd27);

        for (int i = 0; i < 3; i++) kcol(127, 127, 127);
        for (int i = 0; i < 3; i++) icol(255, 255, 255);
        idle();         check("sat_pos", o_data, 13'h0FFF);
        for (int i = 0; i < 5; i++) begin
            idle(); check("hold", o_data, 13'h0FFF);
        end
        for (int i = 0; i < 3; i++) kcol(8'h80, 8'h80, 8'h80);
        idle();         check("sat_neg", o_data, 13'h1000);

        kcol(5, 5, 5); kcol(5, 5, 5);
        do_reset();
        idle();         check("midreset", o_data, 13'd0);
        box_filter("reload");

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
